// File: rtl/eth_rx_framer.sv
// eth_rx_framer
// Receive-side framer that sits in front of the per-port frame FIFO.
// It locks onto the PHY preamble/SFD, then forwards every frame byte from the
// destination MAC through the FCS into the FIFO. The last byte of a frame is
// tagged, and bad frames are tagged as errored. It also captures the
// destination/source MAC for the forwarding lookup and reports per-frame
// length and status.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   rx_dv, rx_er, rxd PHY receive interface (rx_er qualified by rx_dv)
//   fifo_full         downstream FIFO full flag
//   fifo_wr_en        FIFO write strobe
//   fifo_wr_data      {err, last, byte[7:0]}
//   dst_mac, src_mac  captured header addresses, first wire byte in [47:40]
//   hdr_valid         1-cycle pulse once dst_mac/src_mac are complete
//   frame_done        1-cycle pulse at frame end; qualifies frame_err/frame_len
//   frame_err         frame was a runt, oversize, PHY-errored or overflowed
//   frame_len         byte count of the frame (saturating)
module eth_rx_framer #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518,
  parameter int LEN_W     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_dv,
  input  logic             rx_er,
  input  logic [7:0]       rxd,
  input  logic             fifo_full,
  output logic             fifo_wr_en,
  output logic [9:0]       fifo_wr_data,
  output logic [47:0]      dst_mac,
  output logic [47:0]      src_mac,
  output logic             hdr_valid,
  output logic             frame_done,
  output logic             frame_err,
  output logic [LEN_W-1:0] frame_len
);

  typedef enum logic [2:0] {IDLE, PRE, HDR, PAY, DROP} state_t;

  localparam logic [LEN_W-1:0] MIN_LEN   = LEN_W'(MIN_FRAME);
  localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_FRAME);
  localparam logic [LEN_W-1:0] LEN_SAT   = '1;
  localparam logic [LEN_W-1:0] DST_BYTES = LEN_W'(6);
  localparam logic [LEN_W-1:0] HDR_LAST  = LEN_W'(11);

  state_t           state;
  logic [7:0]       hold_byte;
  logic             hold_vld;
  logic [LEN_W-1:0] len;
  logic             wrote_any;
  logic             term_pending;
  logic             dv_low_seen;

  logic             in_frame;
  logic             byte_err;
  logic             full_err;
  logic             go_drop;
  logic             runt;
  logic [LEN_W-1:0] len_inc;

  // A frame is abandoned on a PHY error, on a byte that would push it past
  // the maximum length, or when the held byte is due to be written but the
  // FIFO is full. Because the held byte is always written one byte late, a
  // full FIFO only matters once something is held.
  always_comb begin
    in_frame = (state == HDR) || (state == PAY);
    byte_err = rx_dv && (rx_er || (len == MAX_LEN));
    full_err = hold_vld && fifo_full;
    go_drop  = in_frame && (byte_err || full_err);
    runt     = (state == HDR) || (len < MIN_LEN);
    len_inc  = (len == LEN_SAT) ? len : len + LEN_W'(1);
  end

  // Single-process FSM with registered outputs. The one-byte hold register
  // delays the stream by one byte, so the final byte can be tagged last when
  // rx_dv falls without needing any look-ahead.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      hold_byte    <= '0;
      hold_vld     <= 1'b0;
      len          <= '0;
      wrote_any    <= 1'b0;
      term_pending <= 1'b0;
      dv_low_seen  <= 1'b0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      dst_mac      <= '0;
      src_mac      <= '0;
      hdr_valid    <= 1'b0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
      frame_len    <= '0;
    end else begin
      fifo_wr_en <= 1'b0;
      hdr_valid  <= 1'b0;
      frame_done <= 1'b0;

      if (go_drop) begin
        // Offending byte and held byte are both discarded. If nothing of
        // this frame reached the FIFO, there is no terminator to write.
        // In that case, the status is reported right away.
        state       <= DROP;
        hold_vld    <= 1'b0;
        dv_low_seen <= !rx_dv;
        if (rx_dv) len <= len_inc;
        if (wrote_any) begin
          term_pending <= 1'b1;
        end else begin
          frame_done <= 1'b1;
          frame_err  <= 1'b1;
          frame_len  <= rx_dv ? len_inc : len;
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (rx_dv && (rxd == 8'h55)) state <= PRE;
          end
          PRE: begin
            if (!rx_dv) begin
              state <= IDLE;
            end else if (rxd == 8'hD5) begin
              state        <= HDR;
              len          <= '0;
              hold_vld     <= 1'b0;
              wrote_any    <= 1'b0;
              term_pending <= 1'b0;
            end else if (rxd != 8'h55) begin
              state <= IDLE;
            end
          end
          HDR, PAY: begin
            if (rx_dv) begin
              if (hold_vld) begin
                fifo_wr_en   <= 1'b1;
                fifo_wr_data <= {2'b00, hold_byte};
                wrote_any    <= 1'b1;
              end
              hold_byte <= rxd;
              hold_vld  <= 1'b1;
              len       <= len_inc;
              if (state == HDR) begin
                if (len < DST_BYTES) dst_mac <= {dst_mac[39:0], rxd};
                else                 src_mac <= {src_mac[39:0], rxd};
                if (len == HDR_LAST) begin
                  hdr_valid <= 1'b1;
                  state     <= PAY;
                end
              end
            end else begin
              // Clean end of frame: flush the held byte as the last one.
              if (hold_vld) begin
                fifo_wr_en   <= 1'b1;
                fifo_wr_data <= {runt, 1'b1, hold_byte};
              end
              hold_vld   <= 1'b0;
              frame_done <= 1'b1;
              frame_err  <= runt;
              frame_len  <= len;
              state      <= IDLE;
            end
          end
          DROP: begin
            // Remember that rx_dv went low so that a frame whose terminator
            // is stalled by a full FIFO can still leave once it is written.
            if (!rx_dv) dv_low_seen <= 1'b1;
            if (term_pending) begin
              if (!fifo_full) begin
                fifo_wr_en   <= 1'b1;
                fifo_wr_data <= {1'b1, 1'b1, 8'h00};
                frame_done   <= 1'b1;
                frame_err    <= 1'b1;
                frame_len    <= len;
                term_pending <= 1'b0;
                if (!rx_dv || dv_low_seen) state <= IDLE;
              end
            end else if (!rx_dv || dv_low_seen) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_framer.sv
// tb_eth_rx_framer
// Scoreboard bench for eth_rx_framer. Each frame's expected FIFO writes,
// header capture and status are derived from the frame-level rules (byte
// counts, drop positions), then queued before the frame is driven. A
// separate monitor pops and compares whenever the DUT presents an output.
module tb_eth_rx_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_dv;
  logic        rx_er;
  logic [7:0]  rxd;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [9:0]  fifo_wr_data;
  logic [47:0] dst_mac;
  logic [47:0] src_mac;
  logic        hdr_valid;
  logic        frame_done;
  logic        frame_err;
  logic [10:0] frame_len;

  typedef struct {
    logic        err;
    logic [10:0] len;
    bit          chk_len;
  } status_t;

  logic [9:0]  exp_wr[$];
  logic [95:0] exp_hdr[$];
  status_t     exp_st[$];
  logic [7:0]  frm[$];

  int  n_compared   = 0;
  int  n_mismatched = 0;
  bit  mon_on       = 1'b0;
  logic full_at_edge = 1'b0;

  eth_rx_framer #(.MIN_FRAME(64), .MAX_FRAME(1518), .LEN_W(11)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_dv        (rx_dv),
    .rx_er        (rx_er),
    .rxd          (rxd),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .dst_mac      (dst_mac),
    .src_mac      (src_mac),
    .hdr_valid    (hdr_valid),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .frame_len    (frame_len)
  );

  always #5 clk = ~clk;

  // fifo_full as the DUT saw it at the last rising edge.
  always @(posedge clk) full_at_edge <= fifo_full;

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every DUT output event against the scoreboard queues.
  always @(negedge clk) begin
    if (mon_on) begin
      if (full_at_edge) checkOutput("no_write_while_full", 96'(fifo_wr_en), 96'(0));
      if (fifo_wr_en) begin
        checkOutput("write_expected", 96'(exp_wr.size() != 0), 96'(1));
        if (exp_wr.size() != 0) checkOutput("wr_data", 96'(fifo_wr_data), 96'(exp_wr.pop_front()));
        if (fifo_wr_data[8]) checkOutput("done_with_last", 96'(frame_done), 96'(1));
      end
      if (frame_done) begin
        checkOutput("status_expected", 96'(exp_st.size() != 0), 96'(1));
        if (exp_st.size() != 0) begin
          status_t s;
          s = exp_st.pop_front();
          checkOutput("frame_err", 96'(frame_err), 96'(s.err));
          if (s.chk_len) checkOutput("frame_len", 96'(frame_len), 96'(s.len));
        end
      end
      if (hdr_valid) begin
        checkOutput("hdr_expected", 96'(exp_hdr.size() != 0), 96'(1));
        if (exp_hdr.size() != 0) checkOutput("hdr_macs", {dst_mac, src_mac}, exp_hdr.pop_front());
      end
    end
  end

  task automatic drive(input logic dv, input logic er, input logic [7:0] d, input logic full);
    rx_dv = dv; rx_er = er; rxd = d; fifo_full = full;
    @(posedge clk);
    #1;
  endtask

  // Reference model: works out where (if anywhere) the frame is abandoned,
  // then queues what the FIFO, header and status outputs must show.
  function automatic void modelFrame(input int er_at, input int full_at, input int rst_at);
    int n, d, w;
    logic [47:0] da, sa;
    n = frm.size();
    da = '0; sa = '0;
    for (int i = 0; i < 12 && i < n; i++) begin
      if (i < 6) da = {da[39:0], frm[i]};
      else       sa = {sa[39:0], frm[i]};
    end
    if (rst_at > 0) begin
      w = (rst_at > 2) ? rst_at - 2 : 0;
      for (int i = 0; i < w; i++) exp_wr.push_back({2'b00, frm[i]});
      if (rst_at - 1 >= 12) exp_hdr.push_back({da, sa});
      return;
    end
    d = 0;
    if (er_at > 0) d = er_at;
    if (n > 1518 && (d == 0 || 1519 < d)) d = 1519;
    if (full_at > 0 && (d == 0 || full_at < d)) d = full_at;
    if (d == 0) begin
      for (int i = 0; i < n; i++)
        exp_wr.push_back({(i == n - 1) && (n < 64), i == n - 1, frm[i]});
      exp_st.push_back('{err: (n < 64), len: 11'(n), chk_len: 1'b1});
      if (n >= 12) exp_hdr.push_back({da, sa});
    end else begin
      w = (d > 2) ? d - 2 : 0;
      for (int i = 0; i < w; i++) exp_wr.push_back({2'b00, frm[i]});
      if (w >= 1) exp_wr.push_back(10'h300);
      exp_st.push_back('{err: 1'b1, len: 11'(0), chk_len: 1'b0});
      if (d >= 13) exp_hdr.push_back({da, sa});
    end
  endfunction

  task automatic buildFrame(input int n);
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
  endtask

  task automatic applyStimulus(input int er_at, input int full_at, input int full_len,
                               input int pre, input int gap, input int rst_at);
    int n;
    logic full;
    n = frm.size();
    modelFrame(er_at, full_at, rst_at);
    repeat (pre) drive(1'b1, 1'b0, 8'h55, 1'b0);
    drive(1'b1, 1'b0, 8'hD5, 1'b0);
    for (int i = 1; i <= n; i++) begin
      full = (full_at > 0) && (i >= full_at) && (i < full_at + full_len);
      if (i == rst_at) begin
        rst = 1'b1;
        drive(1'b1, 1'b0, frm[i-1], 1'b0);
        rst = 1'b0;
        checkOutput("rst_wr_en", 96'(fifo_wr_en), 96'(0));
        checkOutput("rst_wr_data", 96'(fifo_wr_data), 96'(0));
        checkOutput("rst_hdr_valid", 96'(hdr_valid), 96'(0));
        checkOutput("rst_frame_done", 96'(frame_done), 96'(0));
        checkOutput("rst_macs", {dst_mac, src_mac}, 96'(0));
        checkOutput("rst_len_err", 96'({frame_err, frame_len}), 96'(0));
        break;
      end
      drive(1'b1, 1'b0 | (i == er_at), frm[i-1], full);
    end
    repeat (gap) drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] hdr_bytes [12];
    int n, mode, er_at, full_at, full_len;
    hdr_bytes = '{8'h01, 8'h80, 8'hC2, 8'h00, 8'h00, 8'h01,
                  8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    rst = 1'b1; rx_dv = 1'b0; rx_er = 1'b0; rxd = 8'h00; fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_wr_en", 96'(fifo_wr_en), 96'(0));
    checkOutput("reset_pulses", 96'({hdr_valid, frame_done, frame_err}), 96'(0));
    checkOutput("reset_len", 96'(frame_len), 96'(0));
    checkOutput("reset_macs", {dst_mac, src_mac}, 96'(0));
    rst = 1'b0;
    mon_on = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0);

    // Legal minimum frame with a known header.
    buildFrame(64);
    for (int i = 0; i < 12; i++) frm[i] = hdr_bytes[i];
    applyStimulus(0, 0, 0, 7, 3, 0);
    // Runt frame.
    buildFrame(40);
    applyStimulus(0, 0, 0, 7, 3, 0);
    // PHY error at byte 30, then a good frame two cycles later.
    buildFrame(100);
    applyStimulus(30, 0, 0, 7, 2, 0);
    buildFrame(80);
    applyStimulus(0, 0, 0, 7, 3, 0);
    // FIFO full from byte 20 for 50 cycles.
    buildFrame(100);
    applyStimulus(0, 20, 50, 7, 3, 0);
    // Largest legal frame, then one byte too long.
    buildFrame(1518);
    applyStimulus(0, 0, 0, 3, 3, 0);
    buildFrame(1519);
    applyStimulus(0, 0, 0, 3, 3, 0);
    // Reset in the middle of a frame, then a clean frame.
    buildFrame(100);
    applyStimulus(0, 0, 0, 7, 3, 30);
    buildFrame(70);
    applyStimulus(0, 0, 0, 7, 3, 0);

    // Randomized frames: good, runt, PHY error and FIFO-full mixes.
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(1, 160);
      mode = $urandom_range(0, 3);
      er_at = 0; full_at = 0; full_len = 0;
      if (mode == 2) er_at = $urandom_range(1, n);
      if (mode == 3 && n >= 4) begin
        full_at  = $urandom_range(2, n - 2);
        full_len = $urandom_range(1, n - full_at);
      end
      buildFrame(n);
      applyStimulus(er_at, full_at, full_len, $urandom_range(1, 8), $urandom_range(1, 4), 0);
    end

    repeat (50) drive(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("writes_drained", 96'(exp_wr.size()), 96'(0));
    checkOutput("status_drained", 96'(exp_st.size()), 96'(0));
    checkOutput("hdr_drained", 96'(exp_hdr.size()), 96'(0));
    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
